// File: rtl/tlb_ptw.sv
// Two-level page-table walker: turns a TLB miss into one or two PTE reads and
// returns a normalized leaf PTE (all-zero on any fault, including timeout).
module tlb_ptw #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] root_ppn_i,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L2_REQ  = 3'd3,
    S_L2_WAIT = 3'd4,
    S_RESPOND = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_vpn0;
  logic [31:0] r_pte;
  logic [31:0] r_mem_addr;
  logic [7:0]  r_wait_cnt;
  logic        r_stale;

  logic [31:0] w_pte_nxt;
  logic [31:0] w_addr_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_stale_nxt;
  logic        w_accept;
  logic        w_unused;

  function automatic logic is_pointer(input logic [31:0] d);
    return d[2] & ~d[1] & ~d[0];
  endfunction

  // L1 non-pointer: invalid or misaligned superpage faults, else 4 MiB leaf.
  function automatic logic [31:0] l1_result(input logic [31:0] d, input logic [9:0] vpn0);
    if (!d[2] || (d[21:12] != 10'd0)) return 32'd0;
    return {d[31:22], vpn0, 9'd0, 1'b1, d[1:0]};
  endfunction

  // L2 must be a valid leaf; a pointer here has nowhere to go.
  function automatic logic [31:0] l2_result(input logic [31:0] d);
    if (!d[2] || (d[1:0] == 2'b00)) return 32'd0;
    return {d[31:12], 9'd0, 1'b1, d[1:0]};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_pte_nxt   = r_pte;
    w_addr_nxt  = r_mem_addr;
    w_cnt_nxt   = r_wait_cnt;
    w_stale_nxt = r_stale;
    w_accept    = 1'b0;
    if (mem_resp_valid_i && r_stale) w_stale_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ptw_req_valid_i) begin
          w_accept    = 1'b1;
          w_addr_nxt  = {root_ppn_i, ptw_vaddr_i[31:22], 2'b00};
          w_state_nxt = S_L1_REQ;
        end
      end
      S_L1_REQ: begin
        if (mem_req_ready_i) begin
          w_state_nxt = S_L1_WAIT;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_L2_REQ: begin
        if (mem_req_ready_i) begin
          w_state_nxt = S_L2_WAIT;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_L1_WAIT, S_L2_WAIT: begin
        // A late response from a timed-out walk is dropped and restarts the wait.
        if (mem_resp_valid_i && r_stale) begin
          w_cnt_nxt = 8'd0;
        end else if (mem_resp_valid_i) begin
          w_state_nxt = S_RESPOND;
          if (r_state == S_L1_WAIT) begin
            if (is_pointer(mem_rdata_i)) begin
              w_state_nxt = S_L2_REQ;
              w_addr_nxt  = {mem_rdata_i[31:12], r_vpn0, 2'b00};
            end else begin
              w_pte_nxt = l1_result(mem_rdata_i, r_vpn0);
            end
          end else begin
            w_pte_nxt = l2_result(mem_rdata_i);
          end
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_state_nxt = S_RESPOND;
          w_pte_nxt   = 32'd0;
          w_stale_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      S_RESPOND: begin
        if (ptw_resp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_stale    <= 1'b0;
      r_wait_cnt <= 8'd0;
      r_pte      <= 32'd0;
      r_mem_addr <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_stale    <= w_stale_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_pte      <= w_pte_nxt;
      r_mem_addr <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_vpn0 <= ptw_vaddr_i[21:12];
  end

  assign ptw_req_ready_o  = !rst && (r_state == S_IDLE);
  assign ptw_resp_valid_o = !rst && (r_state == S_RESPOND);
  assign mem_req_valid_o  = !rst && ((r_state == S_L1_REQ) || (r_state == S_L2_REQ));
  assign mem_resp_ready_o = !rst;
  assign busy_o           = !rst && (r_state != S_IDLE);
  assign ptw_pte_o        = r_pte;
  assign mem_addr_o       = r_mem_addr;

  assign w_unused = ^{ptw_vaddr_i[11:0], mem_rdata_i[11:3]};

endmodule
